// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction prefetch buffer that sits between the fetch stage and the
//   decode stage of the pipelined RV32I core. {pc, instruction} pairs are
//   queued in a circular buffer and handed to decode in order over a
//   valid/ready handshake. A branch/jump flush discards everything buffered.
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous active-high reset
//   fetch_valid  fetch side presents a {fetch_pc, fetch_instr} pair
//   fetch_pc     PC of the fetched instruction
//   fetch_instr  fetched instruction word
//   fetch_en     queue can accept this cycle; drives the PC register enable
//   flush        branch/jump redirect, drops all entries
//   dec_valid    head entry is valid for decode
//   dec_pc       PC of the head entry (0 when dec_valid is low)
//   dec_instr    instruction of the head entry (0 when dec_valid is low)
//   dec_ready    decode consumes the head entry this cycle
//   count        number of occupied entries
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_valid,
  input  logic [XLEN-1:0]        fetch_pc,
  input  logic [XLEN-1:0]        fetch_instr,
  output logic                   fetch_en,
  input  logic                   flush,
  output logic                   dec_valid,
  output logic [XLEN-1:0]        dec_pc,
  output logic [XLEN-1:0]        dec_instr,
  input  logic                   dec_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] pc_mem_d    [DEPTH];
  logic [XLEN-1:0] instr_mem_q [DEPTH];
  logic [XLEN-1:0] instr_mem_d [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  // Handshake qualifiers. fetch_en deliberately ignores dec_ready so the PC
  // enable never depends on the decode stage in the same cycle, and it drops
  // during a flush so the PC can take its redirect target instead.
  always_comb begin
    dec_valid = (count_q != '0);
    fetch_en  = (count_q != FULL_COUNT) && !flush;
    push      = fetch_valid && fetch_en;
    pop       = dec_valid && dec_ready;
  end

  // Head entry is presented straight from storage; zeros when empty so decode
  // never sees stale words from a previously drained slot.
  always_comb begin
    dec_pc    = '0;
    dec_instr = '0;
    if (dec_valid) begin
      dec_pc    = pc_mem_q[rd_ptr_q];
      dec_instr = instr_mem_q[rd_ptr_q];
    end
  end

  assign count = count_q;

  // Pointer and occupancy update. Pointers are AW bits wide, so the +1 wraps
  // DEPTH-1 -> 0 for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Storage write. push already excludes flush through fetch_en, so data
  // presented in a flush cycle is never captured.
  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (push) begin
      pc_mem_d[wr_ptr_q]    = fetch_pc;
      instr_mem_d[wr_ptr_q] = fetch_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry contents survive reset; dec_* masking makes them invisible anyway.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Self-checking bench for fetch_queue (DEPTH=4, XLEN=32). Directed table of
//   per-cycle vectors, hand-written multi-cycle sequences, then randomized
//   traffic compared against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_en;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst;
    logic        flush;
    logic        fv;
    logic [31:0] pc;
    logic        dr;
    logic        chk;
    logic [2:0]  exp_count;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_fen;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  vec_t   vecs[$];
  entry_t model_q[$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_pc    (fetch_pc),
    .fetch_instr (fetch_instr),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .dec_valid   (dec_valid),
    .dec_pc      (dec_pc),
    .dec_instr   (dec_instr),
    .dec_ready   (dec_ready),
    .count       (count)
  );

  // Instruction word paired with each directed PC, so dec_instr can be
  // checked without a second column in the vector table.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return (pc << 4) ^ 32'h0000_0013;
  endfunction

  function automatic vec_t mk(input logic r, input logic f, input logic fv,
                              input logic [31:0] pc, input logic dr,
                              input logic chk, input logic [2:0] ec,
                              input logic ev, input logic [31:0] epc,
                              input logic efen);
    vec_t v;
    v.rst = r; v.flush = f; v.fv = fv; v.pc = pc; v.dr = dr; v.chk = chk;
    v.exp_count = ec; v.exp_valid = ev; v.exp_pc = epc; v.exp_fen = efen;
    return v;
  endfunction

  // Drive one cycle's inputs just after the falling edge, then settle so the
  // combinational fetch_en reflects this cycle's flush.
  task automatic applyStimulus(input logic r, input logic f, input logic fv,
                               input logic [31:0] pc, input logic [31:0] ins,
                               input logic dr);
    @(negedge clk);
    rst         = r;
    flush       = f;
    fetch_valid = fv;
    fetch_pc    = pc;
    fetch_instr = ins;
    dec_ready   = dr;
    #1;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s %s: got 0x%0h expected 0x%0h", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [2:0] ec,
                             input logic ev, input logic [31:0] epc,
                             input logic [31:0] einstr, input logic efen);
    cmp(name, "count",     {29'd0, count},     {29'd0, ec});
    cmp(name, "dec_valid", {31'd0, dec_valid}, {31'd0, ev});
    cmp(name, "dec_pc",    dec_pc,             epc);
    cmp(name, "dec_instr", dec_instr,          einstr);
    cmp(name, "fetch_en",  {31'd0, fetch_en},  {31'd0, efen});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; fetch_valid = 1'b0;
    fetch_pc = '0; fetch_instr = '0; dec_ready = 1'b0;

    // Each row: inputs for the cycle, then the outputs expected in that same
    // cycle (before the edge that acts on those inputs).
    //             rst  fl   fv   pc        dr   chk  cnt  val  exp_pc    fen
    vecs.push_back(mk(1, 0, 0, 32'h00, 0, 0, 3'd0, 0, 32'h00, 1));
    vecs.push_back(mk(1, 0, 0, 32'h00, 0, 1, 3'd0, 0, 32'h00, 1));
    vecs.push_back(mk(0, 0, 1, 32'h00, 0, 1, 3'd0, 0, 32'h00, 1));
    vecs.push_back(mk(0, 0, 1, 32'h04, 0, 1, 3'd1, 1, 32'h00, 1));
    vecs.push_back(mk(0, 0, 1, 32'h08, 0, 1, 3'd2, 1, 32'h00, 1));
    vecs.push_back(mk(0, 0, 1, 32'h0C, 0, 1, 3'd3, 1, 32'h00, 1));
    vecs.push_back(mk(0, 0, 1, 32'h10, 0, 1, 3'd4, 1, 32'h00, 0));
    vecs.push_back(mk(0, 0, 0, 32'h00, 1, 1, 3'd4, 1, 32'h00, 0));
    vecs.push_back(mk(0, 0, 0, 32'h00, 1, 1, 3'd3, 1, 32'h04, 1));
    vecs.push_back(mk(0, 0, 0, 32'h00, 1, 1, 3'd2, 1, 32'h08, 1));
    vecs.push_back(mk(0, 0, 0, 32'h00, 1, 1, 3'd1, 1, 32'h0C, 1));
    vecs.push_back(mk(0, 0, 0, 32'h00, 0, 1, 3'd0, 0, 32'h00, 1));
    vecs.push_back(mk(0, 0, 1, 32'h20, 0, 1, 3'd0, 0, 32'h00, 1));
    vecs.push_back(mk(0, 0, 1, 32'h24, 0, 1, 3'd1, 1, 32'h20, 1));
    vecs.push_back(mk(0, 0, 0, 32'h00, 0, 1, 3'd2, 1, 32'h20, 1));
    vecs.push_back(mk(0, 0, 0, 32'h00, 0, 1, 3'd2, 1, 32'h20, 1));
    vecs.push_back(mk(0, 0, 0, 32'h00, 0, 1, 3'd2, 1, 32'h20, 1));
    vecs.push_back(mk(0, 0, 1, 32'h28, 0, 1, 3'd2, 1, 32'h20, 1));
    vecs.push_back(mk(0, 1, 1, 32'h40, 1, 1, 3'd3, 1, 32'h20, 0));
    vecs.push_back(mk(0, 0, 1, 32'h80, 0, 1, 3'd0, 0, 32'h00, 1));
    vecs.push_back(mk(0, 0, 1, 32'h84, 0, 1, 3'd1, 1, 32'h80, 1));
    vecs.push_back(mk(0, 0, 1, 32'h88, 0, 1, 3'd2, 1, 32'h80, 1));
    vecs.push_back(mk(1, 1, 1, 32'h90, 1, 1, 3'd3, 1, 32'h80, 0));
    vecs.push_back(mk(0, 0, 1, 32'h00, 0, 1, 3'd0, 0, 32'h00, 1));
    vecs.push_back(mk(0, 0, 1, 32'h04, 0, 1, 3'd1, 1, 32'h00, 1));

    $display("[TB] directed vectors");
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].fv, vecs[i].pc,
                    instr_of(vecs[i].pc), vecs[i].dr);
      if (vecs[i].chk)
        checkOutput($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_valid,
                    vecs[i].exp_pc,
                    vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : 32'h0,
                    vecs[i].exp_fen);
    end

    // Streaming through two pointer wraps: occupancy settles at 1 and the
    // head trails the pushed PC by exactly one cycle.
    $display("[TB] streaming with wrap");
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 0);
    for (int k = 0; k < 10; k++) begin
      logic [31:0] pc_k;
      logic [31:0] pc_prev;
      pc_k    = 32'h100 + 32'(4 * k);
      pc_prev = 32'h100 + 32'(4 * (k - 1));
      applyStimulus(0, 0, 1, pc_k, instr_of(pc_k), 1);
      if (k == 0)
        checkOutput("stream0", 3'd0, 1'b0, 32'h0, 32'h0, 1'b1);
      else
        checkOutput($sformatf("stream%0d", k), 3'd1, 1'b1, pc_prev, instr_of(pc_prev), 1'b1);
    end
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
    checkOutput("stream_tail", 3'd1, 1'b1, 32'h124, instr_of(32'h124), 1'b1);
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("stream_empty", 3'd0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Full with a simultaneous pop and push attempt: the push is refused.
    $display("[TB] full with pop");
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 0, 1, 32'h200 + 32'(4 * k), instr_of(32'h200 + 32'(4 * k)), 0);
    applyStimulus(0, 0, 1, 32'h300, instr_of(32'h300), 1);
    checkOutput("full_pop", 3'd4, 1'b1, 32'h200, instr_of(32'h200), 1'b0);
    for (int k = 1; k < 4; k++) begin
      applyStimulus(0, 0, 0, 32'h0, 32'h0, 1);
      checkOutput($sformatf("full_drain%0d", k), 3'(4 - k), 1'b1,
                  32'h200 + 32'(4 * k), instr_of(32'h200 + 32'(4 * k)), 1'b1);
    end
    applyStimulus(0, 0, 0, 32'h0, 32'h0, 0);
    checkOutput("full_empty", 3'd0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Randomized traffic against a queue model.
    $display("[TB] random traffic");
    applyStimulus(1, 0, 0, 32'h0, 32'h0, 0);
    model_q.delete();
    for (int n = 0; n < 1500; n++) begin
      logic r, f, fv, dr, ev, efen;
      logic [31:0] pc, ins, epc, eins;
      logic [2:0] ec;
      r   = ($urandom_range(63) == 0);
      f   = ($urandom_range(15) == 0);
      fv  = ($urandom_range(9) < 7);
      dr  = ($urandom_range(9) < 6);
      pc  = $urandom & 32'hFFFF_FFFC;
      ins = $urandom;
      applyStimulus(r, f, fv, pc, ins, dr);
      ec   = 3'(model_q.size());
      ev   = (model_q.size() != 0);
      epc  = ev ? model_q[0].pc : 32'h0;
      eins = ev ? model_q[0].instr : 32'h0;
      efen = (model_q.size() != DEPTH) && !f;
      checkOutput($sformatf("rand%0d", n), ec, ev, epc, eins, efen);
      if (r || f) begin
        model_q.delete();
      end else begin
        if (ev && dr) void'(model_q.pop_front());
        if (fv && efen) model_q.push_back('{pc, ins});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
